hud_img_writer: RTL and testbench

- Write-side companion to the HUD blob renderer: captures a 2-bit-per-pixel image stream (threshold/colour-class output of the camera path) into the dual-port HUD image RAM.
- The renderer reads the RAM at address (col + row*WIDTH). This block generates the same row-major addresses, write enable and data on the RAM's write port.
- Supports single-shot or continuous frame capture, start-of-frame resynchronisation and error flags.

---
 rtl/hud_pkg.sv | 16 +
 rtl/hud_raster_counter.sv | 59 +++++
 rtl/hud_img_writer.sv | 130 +++++++++++++
 tb/tb_hud_img_writer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// Shared HUD image geometry, pixel class width and writer state encoding.
package hud_pkg;

  localparam int HUD_WIDTH  = 512;
  localparam int HUD_HEIGHT = 240;
  localparam int HUD_ADDR_W = 17;
  localparam int HUD_PIX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } hud_state_t;

endpackage

// File: rtl/hud_raster_counter.sv
// Row-major col/row/linear-address counter; clr and inc together yield the position after (0,0).
// Outputs are registered; o_last flags the pixel at (WIDTH-1, HEIGHT-1).
module hud_raster_counter
  import hud_pkg::*;
#(
  parameter int WIDTH  = HUD_WIDTH,
  parameter int HEIGHT = HUD_HEIGHT,
  parameter int ADDR_W = HUD_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(HEIGHT - 1);

  logic [ADDR_W-1:0] r_col, r_row, r_addr;
  logic [ADDR_W-1:0] w_col_base, w_row_base, w_addr_base;
  logic [ADDR_W-1:0] w_col_nxt, w_row_nxt, w_addr_nxt;

  always_comb begin
    w_col_base  = i_clr ? '0 : r_col;
    w_row_base  = i_clr ? '0 : r_row;
    w_addr_base = i_clr ? '0 : r_addr;
    w_col_nxt   = w_col_base;
    w_row_nxt   = w_row_base;
    w_addr_nxt  = w_addr_base;
    if (i_inc) begin
      // Linear address only ever steps by one; it tracks col + row*WIDTH without a multiplier.
      w_addr_nxt = w_addr_base + ADDR_W'(1);
      if (w_col_base == COL_MAX) begin
        w_col_nxt = '0;
        w_row_nxt = w_row_base + ADDR_W'(1);
      end else begin
        w_col_nxt = w_col_base + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else begin
      r_col  <= w_col_nxt;
      r_row  <= w_row_nxt;
      r_addr <= w_addr_nxt;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_col == COL_MAX) && (r_row == ROW_MAX);

endmodule

// File: rtl/hud_img_writer.sv
// Captures a 2-bpp pixel stream into the HUD image RAM write port in row-major order.
// Write is registered one cycle after acceptance; pix_ready is high only in ARMED/CAPTURE.
module hud_img_writer
  import hud_pkg::*;
#(
  parameter int WIDTH      = HUD_WIDTH,
  parameter int HEIGHT     = HUD_HEIGHT,
  parameter int ADDR_W     = HUD_ADDR_W,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                 i_pixel_clk,
  input  logic                 i_reset_n,
  input  logic                 i_arm,
  input  logic                 i_pix_valid,
  input  logic                 i_pix_sof,
  input  logic [HUD_PIX_W-1:0] i_pix_data,
  output logic                 o_pix_ready,
  output logic                 o_we,
  output logic [ADDR_W-1:0]    o_waddr,
  output logic [HUD_PIX_W-1:0] o_wdata,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_short_frame,
  output logic                 o_overflow
);

  localparam bit ONE_PIXEL = (WIDTH == 1) && (HEIGHT == 1);

  hud_state_t r_state, w_state_nxt;

  logic                 w_write, w_clr, w_inc, w_short, w_ovf, w_arm_ok;
  logic                 w_cnt_last;
  logic [ADDR_W-1:0]    w_cnt_addr;
  logic                 r_we, r_short, r_ovf;
  logic [ADDR_W-1:0]    r_waddr;
  logic [HUD_PIX_W-1:0] r_wdata;

  hud_raster_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .i_clk  (i_pixel_clk),
    .i_rst_n(i_reset_n),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_addr (w_cnt_addr),
    .o_last (w_cnt_last)
  );

  always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_short     = 1'b0;
    w_ovf       = 1'b0;
    w_arm_ok    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ovf = i_pix_valid;
        if (i_arm) begin
          w_arm_ok    = 1'b1;
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (i_pix_valid && i_pix_sof) begin
          w_write     = 1'b1;
          w_clr       = 1'b1;
          w_inc       = 1'b1;
          w_state_nxt = ONE_PIXEL ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (i_pix_valid) begin
          w_write = 1'b1;
          w_inc   = 1'b1;
          // A fresh sof mid-frame restarts the raster at (0,0).
          if (i_pix_sof) begin
            w_clr   = 1'b1;
            w_short = 1'b1;
            if (ONE_PIXEL) w_state_nxt = ST_DONE;
          end else if (w_cnt_last) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_ovf    = i_pix_valid;
        w_arm_ok = i_arm;
        w_state_nxt = (CONTINUOUS || i_arm) ? ST_ARMED : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_short <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_waddr <= w_clr ? '0 : w_cnt_addr;
        r_wdata <= i_pix_data;
      end
      r_short <= w_short | (r_short & ~w_arm_ok);
      r_ovf   <= w_ovf | (r_ovf & ~w_arm_ok);
    end
  end

  assign o_pix_ready   = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  assign o_busy        = o_pix_ready;
  assign o_frame_done  = (r_state == ST_DONE);
  assign o_we          = r_we;
  assign o_waddr       = r_waddr;
  assign o_wdata       = r_wdata;
  assign o_short_frame = r_short;
  assign o_overflow    = r_ovf;

endmodule

// File: tb/tb_hud_img_writer.sv
// Scoreboard bench: small single-shot writer (4x2) and a continuous writer (64x30).
module tb_hud_img_writer;

  localparam int AW  = 4;
  localparam int AH  = 2;
  localparam int BW  = 64;
  localparam int BH  = 30;
  localparam int ADW = 17;

  localparam int M_IDLE = 0;
  localparam int M_ARMED = 1;
  localparam int M_CAPT = 2;
  localparam int M_DONE = 3;

  typedef struct {
    int mode;
    int idx;
    bit ovf;
    bit shrt;
    int w;
    int h;
    bit cont;
  } model_t;

  typedef struct {
    int         addr;
    logic [1:0] data;
    bit         last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst_n, a_arm, a_valid, a_sof;
  logic [1:0] a_data, a_wdata;
  logic a_rdy, a_we, a_busy, a_fd, a_sf, a_ovf;
  logic [ADW-1:0] a_waddr;

  logic b_rst_n, b_arm, b_valid, b_sof;
  logic [1:0] b_data, b_wdata;
  logic b_rdy, b_we, b_busy, b_fd, b_sf, b_ovf;
  logic [ADW-1:0] b_waddr;

  hud_img_writer #(.WIDTH(AW), .HEIGHT(AH), .ADDR_W(ADW), .CONTINUOUS(1'b0)) dut_a (
    .i_pixel_clk(clk), .i_reset_n(a_rst_n), .i_arm(a_arm), .i_pix_valid(a_valid),
    .i_pix_sof(a_sof), .i_pix_data(a_data), .o_pix_ready(a_rdy), .o_we(a_we),
    .o_waddr(a_waddr), .o_wdata(a_wdata), .o_busy(a_busy), .o_frame_done(a_fd),
    .o_short_frame(a_sf), .o_overflow(a_ovf)
  );

  hud_img_writer #(.WIDTH(BW), .HEIGHT(BH), .ADDR_W(ADW), .CONTINUOUS(1'b1)) dut_b (
    .i_pixel_clk(clk), .i_reset_n(b_rst_n), .i_arm(b_arm), .i_pix_valid(b_valid),
    .i_pix_sof(b_sof), .i_pix_data(b_data), .o_pix_ready(b_rdy), .o_we(b_we),
    .o_waddr(b_waddr), .o_wdata(b_wdata), .o_busy(b_busy), .o_frame_done(b_fd),
    .o_short_frame(b_sf), .o_overflow(b_ovf)
  );

  int total = 0;
  int bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  model_t ma, mb;
  int b_frames = 0;
  int b_last_addr[$];

  function automatic void chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic model_t model_reset(input int w, input int h, input bit cont);
    model_t m;
    m.mode = M_IDLE; m.idx = 0; m.ovf = 0; m.shrt = 0;
    m.w = w; m.h = h; m.cont = cont;
    return m;
  endfunction

  // Reference: pixel position is simply the count of pixels since the last sof.
  function automatic bit model_step(inout model_t m, input bit arm, input bit valid,
                                    input bit sof, input logic [1:0] d, output exp_t e);
    bit wr = 0;
    int n = m.w * m.h;
    e.addr = 0; e.data = d; e.last = 0;
    case (m.mode)
      M_IDLE: begin
        if (arm) begin m.ovf = 0; m.shrt = 0; m.mode = M_ARMED; end
        if (valid) m.ovf = 1;
      end
      M_ARMED: begin
        if (valid && sof) begin
          wr = 1; e.addr = 0; m.idx = 1;
        end
      end
      M_CAPT: begin
        if (valid) begin
          wr = 1;
          if (sof) begin m.shrt = 1; e.addr = 0; m.idx = 1; end
          else begin e.addr = m.idx; m.idx++; end
        end
      end
      default: begin
        if (arm) begin m.ovf = 0; m.shrt = 0; end
        if (valid) m.ovf = 1;
        m.mode = (m.cont || arm) ? M_ARMED : M_IDLE;
      end
    endcase
    if (wr) begin
      e.last = (e.addr == n - 1);
      m.mode = e.last ? M_DONE : M_CAPT;
    end
    return wr;
  endfunction

  function automatic void chk_state(input string t, input model_t m, input logic rdy,
                                    input logic busy, input logic fd, input logic ovf, input logic sf);
    bit act = (m.mode == M_ARMED) || (m.mode == M_CAPT);
    chk({t, "_pix_ready"}, rdy, act);
    chk({t, "_busy"}, busy, act);
    chk({t, "_frame_done"}, fd, m.mode == M_DONE);
    chk({t, "_overflow"}, ovf, m.ovf);
    chk({t, "_short_frame"}, sf, m.shrt);
  endfunction

  function automatic void chk_zero(input string t, input logic we, input logic [ADW-1:0] wa,
                                   input logic [1:0] wd, input logic rdy, input logic busy,
                                   input logic fd, input logic sf, input logic ovf);
    chk({t, "_we"}, we, 0);
    chk({t, "_waddr"}, wa, 0);
    chk({t, "_wdata"}, wd, 0);
    chk({t, "_pix_ready"}, rdy, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_frame_done"}, fd, 0);
    chk({t, "_short_frame"}, sf, 0);
    chk({t, "_overflow"}, ovf, 0);
  endfunction

  task automatic cyc_a(input bit arm, input bit valid, input bit sof, input logic [1:0] d);
    exp_t e;
    a_arm = arm; a_valid = valid; a_sof = sof; a_data = d;
    if (model_step(ma, arm, valid, sof, d, e)) qa.push_back(e);
    @(posedge clk); #1;
    chk_state("a", ma, a_rdy, a_busy, a_fd, a_ovf, a_sf);
  endtask

  task automatic cyc_b(input bit arm, input bit valid, input bit sof, input logic [1:0] d);
    exp_t e;
    b_arm = arm; b_valid = valid; b_sof = sof; b_data = d;
    if (model_step(mb, arm, valid, sof, d, e)) qb.push_back(e);
    @(posedge clk); #1;
    chk_state("b", mb, b_rdy, b_busy, b_fd, b_ovf, b_sf);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_rst_n && a_we) begin
      if (qa.size() == 0) chk("a_unexpected_we", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_waddr", a_waddr, e.addr);
        chk("a_wdata", a_wdata, e.data);
        chk("a_done_with_last_write", a_fd, e.last);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_rst_n) begin
      if (b_fd) b_frames++;
      if (b_we) begin
        if (qb.size() == 0) chk("b_unexpected_we", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_waddr", b_waddr, e.addr);
          chk("b_wdata", b_wdata, e.data);
          chk("b_done_with_last_write", b_fd, e.last);
          if (e.last) b_last_addr.push_back(int'(b_waddr));
        end
      end
    end
  end

  initial begin
    logic [1:0] seq [8];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    a_rst_n = 0; a_arm = 0; a_valid = 0; a_sof = 0; a_data = 0;
    b_rst_n = 0; b_arm = 0; b_valid = 0; b_sof = 0; b_data = 0;
    ma = model_reset(AW, AH, 1'b0);
    mb = model_reset(BW, BH, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("a_reset", a_we, a_waddr, a_wdata, a_rdy, a_busy, a_fd, a_sf, a_ovf);
    chk_zero("b_reset", b_we, b_waddr, b_wdata, b_rdy, b_busy, b_fd, b_sf, b_ovf);
    a_rst_n = 1; b_rst_n = 1;

    // Full 4x2 frame with the fixed data pattern.
    cyc_a(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc_a(0, 1, i == 0, seq[i]);
    // Pixel offered during DONE and again in IDLE, then arm clears overflow.
    cyc_a(0, 1, 0, 2'd3);
    cyc_a(0, 0, 0, 0);
    cyc_a(0, 1, 0, 2'd1);
    cyc_a(1, 0, 0, 0);
    // Valid without sof while ARMED is silently discarded.
    for (int i = 0; i < 5; i++) cyc_a(0, 1, 0, 2'($urandom_range(0, 3)));
    // Restart at the third pixel.
    cyc_a(0, 1, 1, 2'd1);
    cyc_a(0, 1, 0, 2'd2);
    cyc_a(0, 1, 1, 2'd3);
    for (int i = 0; i < 7; i++) cyc_a(0, 1, 0, 2'($urandom_range(0, 3)));
    cyc_a(0, 0, 0, 0);
    cyc_a(0, 0, 0, 0);
    chk("a_short_after_restart", a_sf, 1);
    for (int i = 0; i < 400; i++)
      cyc_a($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)));

    // Continuous writer: reset while the write of address 37 is on the bus.
    cyc_b(1, 0, 0, 0);
    cyc_b(0, 1, 1, 2'($urandom_range(0, 3)));
    while (mb.idx < 38) cyc_b(0, 1, 0, 2'($urandom_range(0, 3)));
    chk("b_waddr_before_reset", b_waddr, 37);
    b_rst_n = 0;
    #1;
    chk_zero("b_midreset", b_we, b_waddr, b_wdata, b_rdy, b_busy, b_fd, b_sf, b_ovf);
    qb.delete();
    mb = model_reset(BW, BH, 1'b1);
    @(posedge clk);
    #1;
    b_rst_n = 1;
    chk_state("b_after_reset", mb, b_rdy, b_busy, b_fd, b_ovf, b_sf);

    // Two frames back to back; continuous mode re-arms after each DONE.
    cyc_b(1, 0, 0, 0);
    for (int f = 0; f < 2; f++) begin
      cyc_b(0, 1, 1, 2'($urandom_range(0, 3)));
      for (int guard = 0; guard < 20000 && mb.mode == M_CAPT; guard++)
        cyc_b(0, $urandom_range(0, 7) != 0, 0, 2'($urandom_range(0, 3)));
      chk("b_frame_reached_done", mb.mode, M_DONE);
      cyc_b(0, 0, 0, 0);
    end
    cyc_b(0, 0, 0, 0);
    cyc_b(0, 0, 0, 0);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    chk("b_frame_done_pulses", b_frames, 2);
    chk("b_last_writes", b_last_addr.size(), 2);
    foreach (b_last_addr[i]) chk("b_last_waddr", b_last_addr[i], BW * BH - 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
